// File: rtl/bist_loopback_responder_if.sv
// Handshake bundle between the BIST FSM (master) and the loopback responder (slave).
// Inject_Fault exists only when BIST_LOOPBACK_FAULT_INJECT_EN is defined.
interface bist_loopback_responder_if #(
   parameter int DW = 8
);
   logic          BIST_Mode;
   logic          Transmit_Start;
   logic [DW-1:0] Tx_Data;
   logic          Data_Rdy;
   logic [DW-1:0] Rx_Data;
   logic          Resp_Busy;
   logic          Overflow;
`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
   logic          Inject_Fault;

   modport master (
      output BIST_Mode, Transmit_Start, Tx_Data, Inject_Fault,
      input  Data_Rdy, Rx_Data, Resp_Busy, Overflow
   );
   modport slave (
      input  BIST_Mode, Transmit_Start, Tx_Data, Inject_Fault,
      output Data_Rdy, Rx_Data, Resp_Busy, Overflow
   );
`else
   modport master (
      output BIST_Mode, Transmit_Start, Tx_Data,
      input  Data_Rdy, Rx_Data, Resp_Busy, Overflow
   );
   modport slave (
      input  BIST_Mode, Transmit_Start, Tx_Data,
      output Data_Rdy, Rx_Data, Resp_Busy, Overflow
   );
`endif
endinterface

// File: rtl/bist_loopback_responder.sv
// Far-end loopback partner of the BIST FSM: queues launched bytes and returns each after DELAY cycles.
// Optional one-shot Rx_Data[0] corruption is enabled by defining BIST_LOOPBACK_FAULT_INJECT_EN.
module bist_loopback_responder #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int DELAY = 3
) (
   input logic                       ClK,
   input logic                       Clear_n,
   bist_loopback_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [7:0]    WAIT_LOAD  = 8'(DELAY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE} state_t;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   state_t        state;
   logic [7:0]    wait_cnt;
   logic [DW-1:0] hold;
   logic [DW-1:0] rx_data_q;
   logic [DW-1:0] fault_mask;
   logic          data_rdy_q, busy_q, overflow_q, mode_q;
   logic          push_req, pop, full, push, drop, drive_now;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      push_req   = bus.BIST_Mode & bus.Transmit_Start;
      full       = (count == FULL_COUNT);
      pop        = bus.BIST_Mode && (state == ST_IDLE) && (count != '0);
      push       = push_req && (!full || pop);
      drop       = push_req && full && !pop;
      drive_now  = bus.BIST_Mode && (state == ST_WAIT) && (wait_cnt == 8'd0);
      count_next = count;
      if (push && !pop)      count_next = count + 1'b1;
      else if (pop && !push) count_next = count - 1'b1;
   end

   // NOTE: storage array carries no reset; validity is tracked by count, so only pointers need clearing.
   always_ff @(posedge ClK) begin
      if (push) mem[wr_ptr] <= bus.Tx_Data;
   end

`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
   logic armed;

   always_ff @(posedge ClK or negedge Clear_n) begin
      if (!Clear_n)                armed <= 1'b0;
      else if (!bus.BIST_Mode)     armed <= 1'b0;
      else if (drive_now && armed) armed <= 1'b0;
      else if (bus.Inject_Fault)   armed <= 1'b1;
   end

   assign fault_mask = {{(DW-1){1'b0}}, armed};
`else
   assign fault_mask = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ClK or negedge Clear_n) begin
      if (!Clear_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         state      <= ST_IDLE;
         wait_cnt   <= 8'd0;
         hold       <= '0;
         rx_data_q  <= '0;
         data_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         mode_q     <= 1'b0;
      end else if (!bus.BIST_Mode) begin
         // Flush: an in-flight byte is abandoned, Rx_Data and Overflow keep their values.
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         state      <= ST_IDLE;
         wait_cnt   <= 8'd0;
         data_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         mode_q <= 1'b1;
         if (!mode_q)   overflow_q <= 1'b0;
         else if (drop) overflow_q <= 1'b1;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count      <= count_next;
         data_rdy_q <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  hold     <= mem[rd_ptr];
                  wait_cnt <= WAIT_LOAD;
                  state    <= ST_WAIT;
                  busy_q   <= 1'b1;
               end else begin
                  busy_q   <= (count_next != '0);
               end
            end
            ST_WAIT: begin
               busy_q <= 1'b1;
               if (wait_cnt == 8'd0) begin
                  state      <= ST_DRIVE;
                  data_rdy_q <= 1'b1;
                  rx_data_q  <= hold ^ fault_mask;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_DRIVE: begin
               state  <= ST_IDLE;
               busy_q <= (count_next != '0);
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= (count_next != '0);
            end
         endcase
      end
   end

   assign bus.Data_Rdy  = data_rdy_q;
   assign bus.Rx_Data   = rx_data_q;
   assign bus.Resp_Busy = busy_q;
   assign bus.Overflow  = overflow_q;
endmodule

// File: tb/tb_bist_loopback_responder.sv
// Self-checking bench for bist_loopback_responder: directed scenarios plus random traffic
// checked every cycle against a queue-and-timestamp reference model.
module tb_bist_loopback_responder;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int DELAY = 3;

   logic ClK;
   logic Clear_n;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   bist_loopback_responder_if #(.DW(DW)) bus ();

   bist_loopback_responder #(.DW(DW), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
      .ClK     (ClK),
      .Clear_n (Clear_n),
      .bus     (bus)
   );

   initial ClK = 1'b0;
   always #5 ClK = ~ClK;

   // Reference model: bytes waiting, the byte in flight and the edge it was popped on.
   logic [7:0] m_fifo [$];
   logic [7:0] recv_q [$];
   logic [7:0] m_flight;
   logic [7:0] m_rx;
   bit         m_in_flight;
   bit         m_ovf;
   bit         m_mode_q;
   bit         m_armed;
   bit         exp_rdy;
   bit         exp_busy;
   int         edge_n;
   int         m_pop_edge;
   int         m_next_pop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      m_fifo.delete();
      m_in_flight = 0;
      m_ovf       = 0;
      m_mode_q    = 0;
      m_armed     = 0;
      m_rx        = '0;
      exp_rdy     = 0;
      exp_busy    = 0;
      edge_n      = 0;
      m_pop_edge  = 0;
      m_next_pop  = 0;
   endtask

   task automatic model_edge(input bit mode, input bit start, input logic [7:0] data, input bit inj);
      bit do_pop;
      edge_n++;
      exp_rdy = 0;
      if (!mode) begin
         m_fifo.delete();
         m_in_flight = 0;
         m_next_pop  = 0;
         m_mode_q    = 0;
         m_armed     = 0;
         exp_busy    = 0;
         return;
      end
      if (!m_mode_q) m_ovf = 0;
      m_mode_q = 1;
      if (m_in_flight && edge_n == m_pop_edge + DELAY + 1) m_in_flight = 0;
      if (m_in_flight && edge_n == m_pop_edge + DELAY) begin
         exp_rdy = 1;
         m_rx    = m_flight ^ {7'd0, m_armed};
`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
         if (m_armed) m_armed = 0;
         else if (inj) m_armed = 1;
      end else if (inj) begin
         m_armed = 1;
`endif
      end
      do_pop = (m_fifo.size() > 0) && (edge_n >= m_next_pop);
      if (do_pop) begin
         m_flight    = m_fifo.pop_front();
         m_in_flight = 1;
         m_pop_edge  = edge_n;
         m_next_pop  = edge_n + DELAY + 2;
      end
      if (start) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(data);
         else m_ovf = 1;
      end
      exp_busy = (m_fifo.size() > 0) || m_in_flight;
      if (inj && !mode) m_armed = 0;
   endtask

   task automatic step(input bit mode, input bit start, input logic [7:0] data, input bit inj);
      bus.BIST_Mode      = mode;
      bus.Transmit_Start = start;
      bus.Tx_Data        = data;
`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
      bus.Inject_Fault   = inj;
`endif
      @(posedge ClK);
      model_edge(mode, start, data, inj);
      #1;
      check("data_rdy",  32'(bus.Data_Rdy),  32'(exp_rdy));
      check("rx_data",   32'(bus.Rx_Data),   32'(m_rx));
      check("resp_busy", 32'(bus.Resp_Busy), 32'(exp_busy));
      check("overflow",  32'(bus.Overflow),  32'(m_ovf));
      if (bus.Data_Rdy === 1'b1) recv_q.push_back(bus.Rx_Data);
   endtask

   task automatic idle(input int n, input bit mode);
      for (int i = 0; i < n; i++) step(mode, 1'b0, 8'h00, 1'b0);
   endtask

   function automatic logic [7:0] recv_at(input int i);
      return (recv_q.size() > i) ? recv_q[i] : 8'hxx;
   endfunction

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      Clear_n            = 1'b0;
      bus.BIST_Mode      = 1'b0;
      bus.Transmit_Start = 1'b0;
      bus.Tx_Data        = '0;
`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
      bus.Inject_Fault   = 1'b0;
`endif
      reset_model();
      #1;
      check("reset_data_rdy",  32'(bus.Data_Rdy),  32'd0);
      check("reset_rx_data",   32'(bus.Rx_Data),   32'd0);
      check("reset_resp_busy", 32'(bus.Resp_Busy), 32'd0);
      check("reset_overflow",  32'(bus.Overflow),  32'd0);
      #11 Clear_n = 1'b1;

      // Single byte: Data_Rdy exactly 4 edges after capture, idle one edge after DRIVE.
      idle(2, 1'b1);
      step(1'b1, 1'b1, 8'hA5, 1'b0);
      idle(3, 1'b1);
      check("t1_not_yet", 32'(bus.Data_Rdy), 32'd0);
      idle(1, 1'b1);
      check("t1_rdy",  32'(bus.Data_Rdy), 32'd1);
      check("t1_data", 32'(bus.Rx_Data),  32'hA5);
      idle(1, 1'b1);
      check("t1_busy_low", 32'(bus.Resp_Busy), 32'd0);

      // Four back-to-back bytes, no overflow.
      recv_q.delete();
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
      idle(25, 1'b1);
      check("t2_count", 32'(recv_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t2_order", 32'(recv_at(i)), 32'(i + 1));
      check("t2_no_ovf", 32'(bus.Overflow), 32'd0);

      // Six back-to-back bytes: the sixth is dropped and Overflow sticks.
      recv_q.delete();
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
      idle(35, 1'b1);
      check("t3_count", 32'(recv_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t3_order", 32'(recv_at(i)), 32'(i + 1));
      check("t3_ovf_sticky", 32'(bus.Overflow), 32'd1);

      // BIST_Mode dropped mid-WAIT flushes; re-enable clears Overflow.
      recv_q.delete();
      step(1'b1, 1'b1, 8'h11, 1'b0);
      step(1'b1, 1'b1, 8'h22, 1'b0);
      step(1'b1, 1'b1, 8'h33, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("t4_busy_flushed", 32'(bus.Resp_Busy), 32'd0);
      check("t4_ovf_kept",     32'(bus.Overflow),  32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hEE, 1'b0);
      step(1'b1, 1'b1, 8'h3C, 1'b0);
      check("t4_ovf_cleared", 32'(bus.Overflow), 32'd0);
      idle(12, 1'b1);
      check("t4_count", 32'(recv_q.size()), 32'd1);
      check("t4_byte",  32'(recv_at(0)),    32'h3C);

      // Asynchronous reset while Data_Rdy is high.
      step(1'b1, 1'b1, 8'h5A, 1'b0);
      idle(4, 1'b1);
      check("t5_in_drive", 32'(bus.Data_Rdy), 32'd1);
      #2 Clear_n = 1'b0;
      #1;
      check("t5_rst_data_rdy",  32'(bus.Data_Rdy),  32'd0);
      check("t5_rst_rx_data",   32'(bus.Rx_Data),   32'd0);
      check("t5_rst_resp_busy", 32'(bus.Resp_Busy), 32'd0);
      check("t5_rst_overflow",  32'(bus.Overflow),  32'd0);
      #2 Clear_n = 1'b1;
      reset_model();

`ifdef BIST_LOOPBACK_FAULT_INJECT_EN
      // One-shot fault flips bit 0 of the next returned byte only.
      idle(1, 1'b1);
      recv_q.delete();
      step(1'b1, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'hF0, 1'b0);
      step(1'b1, 1'b1, 8'hF0, 1'b0);
      idle(15, 1'b1);
      check("t6_count",  32'(recv_q.size()), 32'd2);
      check("t6_first",  32'(recv_at(0)),    32'hF1);
      check("t6_second", 32'(recv_at(1)),    32'hF0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 19) != 0), ($urandom_range(0, 1) == 1),
              8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
      end
      idle(20, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bist_loopback_responder.md
Name: bist_loopback_responder

Overview:
- Far-end partner of the BIST FSM; closes its test loop in simulation and on the FPGA loopback build.
- Accepts bytes the BIST FSM launches (Tx_Data qualified by Transmit_Start).
- Queues them in a small FIFO and returns each byte after a fixed turnaround delay, as Rx_Data qualified by a one-cycle Data_Rdy pulse.
- Active only while BIST_Mode is high; otherwise idle and flushed.

Parameters:
- DW, 8, data width of Tx_Data/Rx_Data.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DELAY, 3, WAIT cycles between pop and Data_Rdy; legal range 1..255.

Ports:
- ClK  in  1  system clock, rising edge.
- Clear_n  in  1  asynchronous active-low reset.
- BIST_Mode  in  1  enables responder; 0 = flush and idle.
- Transmit_Start  in  1  one-cycle strobe; Tx_Data valid this cycle.
- Tx_Data  in  DW  byte launched by the BIST FSM.
- Data_Rdy  out  1  one-cycle strobe; Rx_Data valid this cycle.
- Rx_Data  out  DW  returned byte.
- Resp_Busy  out  1  high when FIFO non-empty or state != IDLE.
- Overflow  out  1  sticky; a push was dropped because FIFO full.

Behaviour:
- Reset (Clear_n=0, async): state IDLE, FIFO empty, wait counter 0, Data_Rdy=0, Rx_Data=0, Resp_Busy=0, Overflow=0. Release is synchronous to the next ClK edge.
- All outputs are registered.
- Push:
  - On a ClK edge with BIST_Mode=1 and Transmit_Start=1, Tx_Data is written at the tail.
  - If the FIFO is full and no pop happens on the same edge, the byte is dropped and Overflow is set.
  - A push and a pop on the same edge when full are both accepted; the count is unchanged.
- FSM states: IDLE, WAIT, DRIVE.
  - IDLE: if the FIFO is non-empty, pop the head into the hold register, load counter=DELAY-1, go to WAIT. Else stay.
  - WAIT: counter decrements each edge. At 0, go to DRIVE; Data_Rdy=1 and Rx_Data=hold are registered on that edge.
  - DRIVE: Data_Rdy drops on the next edge, go to IDLE. Rx_Data holds its last value until the next DRIVE.
- Latency:
  - With an empty FIFO and IDLE, a byte pushed at edge t0 is popped at t0+1.
  - Data_Rdy is high during the cycle after edge t0+DELAY+1. For DELAY=3, Data_Rdy is high 4 clocks after capture.
- Throughput: one byte per DELAY+2 clocks. Bytes are returned in push order, never reordered or duplicated.
- Push into an empty FIFO on the same edge as IDLE evaluates: the pop waits for the next edge. There is no bypass.
- BIST_Mode falling to 0:
  - At the next edge, the FIFO is flushed, the state goes to IDLE, Data_Rdy=0 and the counter is cleared.
  - A DRIVE in progress is cut; no pulse is produced after the flush edge.
  - Overflow clears only on reset or on a 0->1 edge of BIST_Mode.
- Transmit_Start while BIST_Mode=0 is ignored.
- Pointers wrap modulo DEPTH. Count is held separately so full and empty are unambiguous.
- Reset asserted mid-WAIT or mid-DRIVE: outputs go to their reset values immediately and asynchronously.

Optional Feature:
- Macro: BIST_LOOPBACK_FAULT_INJECT_EN.
- When defined:
  - Adds input port Inject_Fault (1 bit).
  - A 1 sampled on any edge arms a one-shot fault.
  - The next byte driven has Rx_Data[0] inverted; the fault then disarms.
  - A second arm while already armed has no further effect.
  - Arming is cleared by reset and by BIST_Mode=0.
- When undefined: the port is absent and Rx_Data always equals the queued byte.

Test Plan:
- Reset, then BIST_Mode=1; single push Tx_Data=8'hA5 at edge t0 -> Data_Rdy high exactly in the cycle after t0+4 (DELAY=3), Rx_Data=8'hA5, Resp_Busy low one clock after DRIVE.
- Four back-to-back pushes 8'h01,02,03,04 -> four Data_Rdy pulses spaced 5 clocks apart, data in order, Overflow=0.
- Six back-to-back pushes with DEPTH=4 -> first pop frees one slot; exactly one byte (the 6th, 8'h06) is dropped, Overflow=1 and sticky, five bytes returned in order.
- Three bytes queued, BIST_Mode dropped mid-WAIT -> no further Data_Rdy, Resp_Busy=0 next edge; re-enable clears Overflow, and a new push 8'h3C returns only 8'h3C.
- Clear_n pulsed low during DRIVE -> Data_Rdy, Rx_Data, Resp_Busy, Overflow all 0 immediately, without waiting for a clock edge.
- With BIST_LOOPBACK_FAULT_INJECT_EN: Inject_Fault pulse, then push 8'hF0 and 8'hF0 -> returns 8'hF1 then 8'hF0.
